alu_issue_scheduler: RTL

- Shares the single integer ALU (incl. mul/div/branch compare) among NUM_REQ reservation-station issue ports.
- Round-robin grant; latches winner's aluop, operands and ROB tag; holds ALU inputs stable for the op's latency class.
- Captures result/take_branch and presents it to the CDB with a valid/ready handshake.
- Sits between reservation stations and ALU; output feeds CDB arbiter.

---
 rtl/alu_issue_scheduler.sv | 114 +++++++++++
 1 files changed

// File: rtl/alu_issue_scheduler.sv
// alu_issue_scheduler: round-robin issue of reservation-station ops onto one shared ALU,
// holding operands for the op's latency class and handing the result to the CDB.
module alu_issue_scheduler #(
    parameter int NUM_REQ = 4,
    parameter int TAG_W   = 6,
    parameter int OP_W    = 6,
    parameter int MUL_LAT = 3,
    parameter int DIV_LAT = 16
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [NUM_REQ-1:0]       req_valid,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic [NUM_REQ*OP_W-1:0]  req_op,
    input  logic [NUM_REQ-1:0]       req_usign,
    input  logic [NUM_REQ*2-1:0]     req_class,
    input  logic [NUM_REQ*64-1:0]    req_a,
    input  logic [NUM_REQ*64-1:0]    req_b,
    input  logic [NUM_REQ*TAG_W-1:0] req_tag,
    input  logic                     flush,
    output logic [OP_W-1:0]          alu_op,
    output logic                     alu_usign,
    output logic [63:0]              alu_a,
    output logic [63:0]              alu_b,
    input  logic [63:0]              alu_result,
    input  logic                     alu_take_branch,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [63:0]              out_result,
    output logic                     out_take_branch,
    output logic [TAG_W-1:0]         out_tag,
    output logic                     busy
);
    localparam int PW = NUM_REQ > 1 ? $clog2(NUM_REQ) : 1;
    localparam int CW = $clog2(DIV_LAT > MUL_LAT ? DIV_LAT : MUL_LAT) + 1;

    typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

    state_t          state;
    logic [PW-1:0]   rr_ptr;
    logic [CW-1:0]   count;
    logic [TAG_W-1:0] tag;
    logic [PW-1:0]   win;
    logic            any;
    logic            grant;
    logic [1:0]      cls;
    logic [CW-1:0]   cnt_init;

    // First valid request at or after rr_ptr, wrapping.
    always_comb begin
        any = 1'b0;
        win = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!any && req_valid[PW'((int'(rr_ptr) + i) % NUM_REQ)]) begin
                any = 1'b1;
                win = PW'((int'(rr_ptr) + i) % NUM_REQ);
            end
        end
    end

    assign grant     = state == IDLE && !flush && any;
    assign req_ready = (grant && reset_n) ? NUM_REQ'(1) << win : '0;
    assign cls       = req_class[win*2 +: 2];
    assign cnt_init  = cls == 2'd1 ? CW'(MUL_LAT - 1) : cls == 2'd2 ? CW'(DIV_LAT - 1) : '0;
    assign busy      = state != IDLE;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state           <= IDLE;
            rr_ptr          <= '0;
            count           <= '0;
            tag             <= '0;
            alu_op          <= '0;
            alu_usign       <= 1'b0;
            alu_a           <= '0;
            alu_b           <= '0;
            out_valid       <= 1'b0;
            out_result      <= '0;
            out_take_branch <= 1'b0;
            out_tag         <= '0;
        end else if (flush) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            count     <= '0;
        end else begin
            case (state)
                IDLE: if (grant) begin
                    alu_op    <= req_op[win*OP_W +: OP_W];
                    alu_usign <= req_usign[win];
                    alu_a     <= req_a[win*64 +: 64];
                    alu_b     <= req_b[win*64 +: 64];
                    tag       <= req_tag[win*TAG_W +: TAG_W];
                    rr_ptr    <= win == PW'(NUM_REQ - 1) ? '0 : win + 1'b1;
                    count     <= cnt_init;
                    state     <= EXEC;
                end
                EXEC: if (count == '0) begin
                    out_result      <= alu_result;
                    out_take_branch <= alu_take_branch;
                    out_tag         <= tag;
                    out_valid       <= 1'b1;
                    state           <= DONE;
                end else begin
                    count <= count - 1'b1;
                end
                DONE: if (out_ready) begin
                    out_valid <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
